// File: rtl/parity_pkg.sv
// Shared constants for the parity frame blocks: FSM encoding and mode selects.
package parity_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/parity_frame_engine_if.sv
// Beat input stream and frame result stream of the parity frame engine.
// Both streams use valid/ready: a transfer happens on a rising edge where valid and ready
// are both high; a producer holds valid and its payload stable until that transfer.
interface parity_frame_engine_if #(
    parameter int DATA_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_par;
    logic              out_valid;
    logic              out_ready;
    logic              out_par;
    logic              out_err;

    modport master (
        output in_valid, in_data, in_par, out_ready,
        input  in_ready, out_valid, out_par, out_err
    );

    modport slave (
        input  in_valid, in_data, in_par, out_ready,
        output in_ready, out_valid, out_par, out_err
    );
endinterface

// File: rtl/parity_xor_reduce.sv
// Combinational XOR reduction of one data word, optionally inverted (odd parity / carry-in).
module parity_xor_reduce #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              invert_i,
    output logic              par_o
);
    assign par_o = (^data_i) ^ invert_i;
endmodule

// File: rtl/parity_frame_engine.sv
// Frame parity generator/checker: XOR-accumulates FRAME_LEN beats, emits one result per frame
// and keeps a saturating count of accepted results flagged as errors.
module parity_frame_engine
    import parity_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  odd_mode,
    input  logic                  check_mode,
    parity_frame_engine_if.slave  bus,
    output logic [CNT_W-1:0]      err_count,
    output logic                  busy,
    output logic [1:0]            dbg_state
);
    localparam int BCW = $clog2(FRAME_LEN) + 1;
    localparam logic [BCW-1:0] LAST_CNT = BCW'(FRAME_LEN - 1);

    logic [1:0]       state_q, state_d;
    logic             acc_q, acc_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
    logic             odd_q, odd_d;
    logic             chk_q, chk_d;
    logic             out_par_q, out_par_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic odd_eff, chk_eff, par_full, beat_acc, res_acc, is_last;

    // Modes come straight from the pins on the first beat, from the latched copy afterwards.
    assign odd_eff = (state_q == ST_IDLE) ? odd_mode   : odd_q;
    assign chk_eff = (state_q == ST_IDLE) ? check_mode : chk_q;

    // par_full is the frame parity including this beat; acc_q is zero in IDLE.
    parity_xor_reduce #(.DATA_W(DATA_W)) u_reduce (
        .data_i   (bus.in_data),
        .invert_i (acc_q ^ odd_eff),
        .par_o    (par_full)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beat_cnt_d  = beat_cnt_q;
        odd_d       = odd_q;
        chk_d       = chk_q;
        out_par_d   = out_par_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;

        bus.in_ready  = (state_q != ST_RESULT);
        bus.out_valid = (state_q == ST_RESULT);
        bus.out_par   = out_par_q;
        bus.out_err   = out_err_q;
        busy          = (state_q != ST_IDLE);

        beat_acc = bus.in_valid & bus.in_ready;
        res_acc  = bus.out_valid & bus.out_ready;
        is_last  = (state_q == ST_IDLE) ? (FRAME_LEN == 1) : (beat_cnt_q == LAST_CNT);

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (beat_acc) begin
                    acc_d      = par_full ^ odd_eff;
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                    if (state_q == ST_IDLE) begin
                        odd_d = odd_mode;
                        chk_d = check_mode;
                    end
                    if (is_last) begin
                        state_d   = ST_RESULT;
                        out_par_d = par_full;
                        out_err_d = (chk_eff == MODE_CHK) & (par_full ^ bus.in_par);
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_RESULT: begin
                if (res_acc) begin
                    state_d    = ST_IDLE;
                    acc_d      = 1'b0;
                    beat_cnt_d = '0;
                    if (out_err_q && !(&err_count_q))
                        err_count_d = err_count_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= 1'b0;
            beat_cnt_q  <= '0;
            odd_q       <= PAR_EVEN;
            chk_q       <= MODE_GEN;
            out_par_q   <= 1'b0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beat_cnt_q  <= beat_cnt_d;
            odd_q       <= odd_d;
            chk_q       <= chk_d;
            out_par_q   <= out_par_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_parity_frame_engine.sv
// Directed and randomized bench for parity_frame_engine: single-word instance plus 4-beat
// instance with a 2-bit error counter, checked against a countones-based reference.
module tb_parity_frame_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    parity_frame_engine_if #(.DATA_W(4)) a_if ();
    parity_frame_engine_if #(.DATA_W(4)) b_if ();

    logic       a_odd, a_chk, a_busy;
    logic [7:0] a_cnt;
    logic [1:0] a_state;
    logic       b_odd, b_chk, b_busy;
    logic [1:0] b_cnt;
    logic [1:0] b_state;

    parity_frame_engine #(.DATA_W(4), .FRAME_LEN(1), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .odd_mode(a_odd), .check_mode(a_chk),
        .bus(a_if.slave), .err_count(a_cnt), .busy(a_busy), .dbg_state(a_state)
    );

    parity_frame_engine #(.DATA_W(4), .FRAME_LEN(4), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .odd_mode(b_odd), .check_mode(b_chk),
        .bus(b_if.slave), .err_count(b_cnt), .busy(b_busy), .dbg_state(b_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Parity bit that makes the total ones count (data + parity) odd in odd mode, even otherwise.
    function automatic logic ref_par(input logic [31:0] bits, input logic odd);
        return (($countones(bits) % 2) == 1) ^ odd;
    endfunction

    task automatic b_beat(input logic [3:0] d, input logic ip, input logic om, input logic cm);
        int n;
        b_if.in_valid = 1'b1;
        b_if.in_data  = d;
        b_if.in_par   = ip;
        b_odd         = om;
        b_chk         = cm;
        n = 0;
        while (b_if.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_beat_ready", b_if.in_ready, 1'b1);
        @(posedge clk); #1;
        b_if.in_valid = 1'b0;
        b_if.in_data  = 4'($urandom);
        b_if.in_par   = 1'($urandom);
    endtask

    // Beats after the first carry inverted modes/in_par: the engine must ignore them.
    task automatic b_frame(input logic [15:0] data, input logic om, input logic cm,
                           input logic ip, input int max_gap, input int hold);
        logic exp_p, exp_e;
        int   gap;
        exp_p = ref_par({16'h0, data}, om);
        exp_e = cm ? (exp_p ^ ip) : 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_beat(data[4*i +: 4], (i == 3) ? ip : ~ip, (i == 0) ? om : ~om, (i == 0) ? cm : ~cm);
            if (i < 3) begin
                check("b_no_early_valid", b_if.out_valid, 1'b0);
                gap = $urandom_range(0, max_gap);
                repeat (gap) begin
                    b_odd = 1'($urandom);
                    b_chk = 1'($urandom);
                    @(posedge clk); #1;
                end
            end
        end
        check("b_out_valid", b_if.out_valid, 1'b1);
        check("b_out_par", b_if.out_par, exp_p);
        check("b_out_err", b_if.out_err, exp_e);
        check("b_in_ready_result", b_if.in_ready, 1'b0);
        check("b_busy_result", b_busy, 1'b1);
        b_if.in_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            b_if.in_data = 4'($urandom);
            @(posedge clk); #1;
            check("b_hold_valid", b_if.out_valid, 1'b1);
            check("b_hold_par", b_if.out_par, exp_p);
            check("b_hold_err", b_if.out_err, exp_e);
            check("b_hold_in_ready", b_if.in_ready, 1'b0);
        end
        b_if.in_valid  = 1'b0;
        b_if.out_ready = 1'b1;
        @(posedge clk); #1;
        b_if.out_ready = 1'b0;
        if (exp_e && exp_cnt < 3) exp_cnt++;
        check("b_valid_after_accept", b_if.out_valid, 1'b0);
        check("b_err_count", b_cnt, exp_cnt);
        check("b_in_ready_idle", b_if.in_ready, 1'b1);
        check("b_busy_idle", b_busy, 1'b0);
    endtask

    task automatic a_word(input logic [3:0] d, input logic om, input logic exp_p);
        a_if.in_valid = 1'b1;
        a_if.in_data  = d;
        a_if.in_par   = 1'($urandom);
        a_odd         = om;
        a_chk         = 1'b0;
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        check("a_out_valid", a_if.out_valid, 1'b1);
        check("a_out_par", a_if.out_par, exp_p);
        check("a_out_par_ref", a_if.out_par, ref_par({28'h0, d}, om));
        check("a_out_err", a_if.out_err, 1'b0);
        check("a_in_ready", a_if.in_ready, 1'b0);
        a_if.out_ready = 1'b1;
        @(posedge clk); #1;
        a_if.out_ready = 1'b0;
        check("a_valid_after_accept", a_if.out_valid, 1'b0);
        check("a_err_count", a_cnt, 8'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic        om, cm, ip;

        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_par = 1'b0; a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_par = 1'b0; b_if.out_ready = 1'b0;
        a_odd = 1'b0; a_chk = 1'b0; b_odd = 1'b0; b_chk = 1'b0;

        // Reset state of both instances.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_b_in_ready", b_if.in_ready, 1'b1);
        check("rst_b_out_valid", b_if.out_valid, 1'b0);
        check("rst_b_out_par", b_if.out_par, 1'b0);
        check("rst_b_out_err", b_if.out_err, 1'b0);
        check("rst_b_err_count", b_cnt, 2'd0);
        check("rst_b_busy", b_busy, 1'b0);
        check("rst_b_state", b_state, 2'd0);
        check("rst_a_in_ready", a_if.in_ready, 1'b1);
        check("rst_a_out_valid", a_if.out_valid, 1'b0);
        check("rst_a_err_count", a_cnt, 8'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-word parity, odd mode, generate.
        a_word(4'b0000, 1'b1, 1'b1);
        a_word(4'b0111, 1'b1, 1'b0);

        // Four-beat frames: even generate, odd check good, odd check bad with long stall.
        b_frame(16'h0F31, 1'b0, 1'b0, 1'b0, 0, 0);
        b_frame(16'h0F31, 1'b1, 1'b1, 1'b0, 0, 0);
        b_frame(16'h0F31, 1'b1, 1'b1, 1'b1, 3, 5);
        check("b_err_count_one", b_cnt, 2'd1);

        // Saturating counter: five error frames after a fresh reset.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            d  = 16'($urandom);
            om = 1'($urandom);
            b_frame(d, om, 1'b1, ~ref_par({16'h0, d}, om), 1, 0);
        end
        check("b_err_count_sat", b_cnt, 2'd3);

        // Reset after two beats discards the partial frame (acc would be 1 if kept).
        b_beat(4'h1, 1'b0, 1'b0, 1'b0);
        b_beat(4'h0, 1'b0, 1'b0, 1'b0);
        do_reset();
        check("mid_rst_out_valid", b_if.out_valid, 1'b0);
        check("mid_rst_busy", b_busy, 1'b0);
        check("mid_rst_state", b_state, 2'd0);
        check("mid_rst_err_count", b_cnt, 2'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("mid_rst_no_result", b_if.out_valid, 1'b0);
        end
        b_frame(16'h0000, 1'b0, 1'b0, 1'b0, 0, 0);

        // Randomized frames with input gaps, mode toggling and output stalls.
        for (int k = 0; k < 24; k++) begin
            d  = 16'($urandom);
            om = 1'($urandom);
            cm = 1'($urandom);
            ip = 1'($urandom);
            b_frame(d, om, cm, ip, 2, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
